ps2_mouse_packet: RTL and testbench

- Sits directly downstream of the PS/2 byte receiver in the Paint PS/2 path. It consumes validated bytes from the mouse in stream mode.
- Assembles standard 3-byte mouse packets: status, X delta, Y delta.
- Decodes the button state and accumulates a clamped absolute cursor position in screen coordinates for the paint/VGA logic.
- Resynchronises on framing loss via the status-byte sync bit and an inter-byte timeout.

---
 rtl/ps2_mouse_packet_if.sv | 19 +
 rtl/ps2_mouse_packet.sv | 189 ++++++++++++++++++
 tb/tb_ps2_mouse_packet.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_packet_if.sv
// Byte stream from the PS/2 receiver into the mouse packet decoder.
// The master drives a byte strobe or an error strobe, one cycle each.
interface ps2_mouse_packet_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_err
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input rx_err
    );
endinterface

// File: rtl/ps2_mouse_packet.sv
// PS/2 stream-mode mouse packet assembler with clamped cursor tracking.
// Resyncs on a bad status sync bit, a receiver error or an inter-byte timeout.
module ps2_mouse_packet #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int TIMEOUT_CYC = 54000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stream_en,
    ps2_mouse_packet_if.slave   rx,
    output logic [X_W-1:0]      pos_x,
    output logic [Y_W-1:0]      pos_y,
    output logic                btn_l,
    output logic                btn_r,
    output logic                btn_m,
    output logic                pkt_valid,
    output logic                sync_err
);

    localparam int AW = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0]        TO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic signed [AW-1:0] X_MAX   = AW'(SCREEN_W - 1);
    localparam logic signed [AW-1:0] Y_MAX   = AW'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2
    } state_t;

    // Bit 3 of the status byte is only a sync marker, so it is not kept.
    typedef struct packed {
        logic       ovf_y;
        logic       ovf_x;
        logic       sgn_y;
        logic       sgn_x;
        logic [2:0] btn;
    } status_t;

    state_t  state;
    state_t  state_nx;
    status_t status_q;
    logic [7:0] xbyte_q;
    logic [CW-1:0] to_cnt;

    logic byte_ok;
    logic timeout;
    logic latch_s;
    logic latch_x;
    logic apply;
    logic err_evt;

    logic signed [AW-1:0] dx;
    logic signed [AW-1:0] dy;
    logic signed [AW-1:0] nx;
    logic signed [AW-1:0] ny;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;

    assign byte_ok = rx.rx_valid && !rx.rx_err;

    // A byte arriving on the last allowed cycle still belongs to the packet.
    assign timeout = (state != WAIT_B0)
                  && (to_cnt == TO_LAST)
                  && !rx.rx_valid
                  && !rx.rx_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_B0;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!stream_en || rx.rx_err || timeout) begin
            state_nx = WAIT_B0;
        end else if (rx.rx_valid) begin
            unique case (state)
                WAIT_B0: if (rx.rx_data[3]) state_nx = WAIT_B1;
                WAIT_B1: state_nx = WAIT_B2;
                WAIT_B2: state_nx = WAIT_B0;
                default: state_nx = WAIT_B0;
            endcase
        end
    end

    always_comb begin
        latch_s = 1'b0;
        latch_x = 1'b0;
        apply   = 1'b0;
        err_evt = 1'b0;
        if (stream_en) begin
            unique case (1'b1)
                rx.rx_err: err_evt = 1'b1;
                timeout:   err_evt = 1'b1;
                byte_ok && (state == WAIT_B0) && rx.rx_data[3]:
                    latch_s = 1'b1;
                byte_ok && (state == WAIT_B0) && !rx.rx_data[3]:
                    err_evt = 1'b1;
                byte_ok && (state == WAIT_B1):
                    latch_x = 1'b1;
                byte_ok && (state == WAIT_B2):
                    apply = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !stream_en || rx.rx_valid || rx.rx_err
            || timeout || (state == WAIT_B0)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Y byte is consumed straight off the bus on the apply cycle.
    always_comb begin
        dx = AW'($signed({status_q.sgn_x, xbyte_q}));
        dy = AW'($signed({status_q.sgn_y, rx.rx_data}));
        if (status_q.ovf_x) dx = '0;
        if (status_q.ovf_y) dy = '0;
        nx = $signed({{(AW-X_W){1'b0}}, pos_x}) + dx;
        ny = $signed({{(AW-Y_W){1'b0}}, pos_y}) - dy;
    end

    always_comb begin
        if (nx < 0) begin
            cx = '0;
        end else if (nx > X_MAX) begin
            cx = X_W'(SCREEN_W - 1);
        end else begin
            cx = nx[X_W-1:0];
        end
        if (ny < 0) begin
            cy = '0;
        end else if (ny > Y_MAX) begin
            cy = Y_W'(SCREEN_H - 1);
        end else begin
            cy = ny[Y_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= '0;
            xbyte_q   <= '0;
            pos_x     <= X_W'(SCREEN_W / 2);
            pos_y     <= Y_W'(SCREEN_H / 2);
            btn_l     <= 1'b0;
            btn_r     <= 1'b0;
            btn_m     <= 1'b0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            pkt_valid <= apply;
            sync_err  <= err_evt;
            if (latch_s) begin
                status_q <= '{
                    ovf_y: rx.rx_data[7],
                    ovf_x: rx.rx_data[6],
                    sgn_y: rx.rx_data[5],
                    sgn_x: rx.rx_data[4],
                    btn:   rx.rx_data[2:0]
                };
            end
            if (latch_x) begin
                xbyte_q <= rx.rx_data;
            end
            if (apply) begin
                pos_x <= cx;
                pos_y <= cy;
                btn_l <= status_q.btn[0];
                btn_r <= status_q.btn[1];
                btn_m <= status_q.btn[2];
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Bench for ps2_mouse_packet: packet table into a scoreboard,
// plus hand-written resync, timeout, gating and reset sequences.
module tb_ps2_mouse_packet;

    logic       clk = 1'b0;
    logic       rst;
    logic       stream_en;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       btn_l;
    logic       btn_r;
    logic       btn_m;
    logic       pkt_valid;
    logic       sync_err;

    ps2_mouse_packet_if rx_if ();

    ps2_mouse_packet dut (
        .clk       (clk),
        .rst       (rst),
        .stream_en (stream_en),
        .rx        (rx_if),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .btn_m     (btn_m),
        .pkt_valid (pkt_valid),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int btn;
    } exp_t;

    typedef struct {
        bit       do_rst;
        bit [7:0] b0;
        bit [7:0] b1;
        bit [7:0] b2;
        int       ex;
        int       ey;
        int       ebtn;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   sync_cnt = 0;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (pkt_valid || sync_err) begin
            chk("pv_se_exclusive", int'(pkt_valid & sync_err), 0);
        end
        if (sync_err) sync_cnt++;
        if (pkt_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pkt_valid: got pos %0d,%0d",
                         pos_x, pos_y);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pkt_pos_x", int'(pos_x), e.x);
                chk("pkt_pos_y", int'(pos_y), e.y);
                chk("pkt_btn", int'({btn_m, btn_r, btn_l}), e.btn);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input bit [7:0] b);
        repeat (2) @(negedge clk);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_err(input bit with_byte, input bit [7:0] b);
        repeat (2) @(negedge clk);
        rx_if.rx_data  = b;
        rx_if.rx_valid = with_byte;
        rx_if.rx_err   = 1'b1;
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
        rx_if.rx_err   = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_pkt(input bit [7:0] b0, input bit [7:0] b1,
                            input bit [7:0] b2, input int ex,
                            input int ey, input int ebtn);
        exp_t e;
        e.x   = ex;
        e.y   = ey;
        e.btn = ebtn;
        send_byte(b0);
        send_byte(b1);
        sb.push_back(e);
        send_byte(b2);
        wait_drain();
    endtask

    task automatic chk_outs(string tag, int ex, int ey, int ebtn);
        chk({tag, "_x"}, int'(pos_x), ex);
        chk({tag, "_y"}, int'(pos_y), ey);
        chk({tag, "_btn"}, int'({btn_m, btn_r, btn_l}), ebtn);
    endtask

    vec_t vt[16];

    initial begin
        int s0;
        int cyc;

        vt[0]  = '{1'b1, 8'h08, 8'h05, 8'h03, 325, 237, 0};
        vt[1]  = '{1'b1, 8'h39, 8'hFB, 8'hFD, 315, 243, 1};
        vt[2]  = '{1'b0, 8'h0A, 8'h00, 8'h00, 315, 243, 2};
        vt[3]  = '{1'b0, 8'h18, 8'h80, 8'h7F, 187, 116, 0};
        vt[4]  = '{1'b0, 8'h18, 8'h80, 8'h7F,  59,   0, 0};
        vt[5]  = '{1'b0, 8'h18, 8'h80, 8'h7F,   0,   0, 0};
        vt[6]  = '{1'b0, 8'h18, 8'h80, 8'h7F,   0,   0, 0};
        vt[7]  = '{1'b0, 8'h08, 8'h7F, 8'h00, 127,   0, 0};
        vt[8]  = '{1'b0, 8'h28, 8'h7F, 8'h80, 254, 128, 0};
        vt[9]  = '{1'b0, 8'h28, 8'h7F, 8'h80, 381, 256, 0};
        vt[10] = '{1'b0, 8'h28, 8'h7F, 8'h80, 508, 384, 0};
        vt[11] = '{1'b0, 8'h28, 8'h7F, 8'h80, 635, 479, 0};
        vt[12] = '{1'b0, 8'h28, 8'h7F, 8'h80, 639, 479, 0};
        vt[13] = '{1'b1, 8'h49, 8'h10, 8'h10, 320, 224, 1};
        vt[14] = '{1'b0, 8'h88, 8'h10, 8'h10, 336, 224, 0};
        vt[15] = '{1'b0, 8'h0C, 8'hF0, 8'hF0, 576,   0, 4};

        rst            = 1'b1;
        stream_en      = 1'b1;
        rx_if.rx_data  = 8'h00;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_err   = 1'b0;
        do_reset();

        chk_outs("reset", 320, 240, 0);
        chk("reset_pkt_valid", int'(pkt_valid), 0);
        chk("reset_sync_err", int'(sync_err), 0);

        s0 = sync_cnt;
        for (int i = 0; i < 16; i++) begin
            if (vt[i].do_rst) do_reset();
            send_pkt(vt[i].b0, vt[i].b1, vt[i].b2,
                     vt[i].ex, vt[i].ey, vt[i].ebtn);
        end
        chk("table_no_sync_err", sync_cnt - s0, 0);

        // Lone byte without the sync bit must not shift framing.
        do_reset();
        s0 = sync_cnt;
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        chk("lone_b0_sync_err", sync_cnt - s0, 1);
        send_pkt(8'h08, 8'h01, 8'h01, 321, 239, 0);

        do_reset();
        s0 = sync_cnt;
        send_byte(8'h08);
        cyc = 0;
        while (!sync_err && cyc < 60000) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_cycle", cyc, 54000);
        repeat (3) @(negedge clk);
        chk("timeout_sync_err", sync_cnt - s0, 1);
        send_pkt(8'h08, 8'h01, 8'h01, 321, 239, 0);

        do_reset();
        s0 = sync_cnt;
        send_byte(8'h08);
        send_err(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        chk("rx_err_sync_err", sync_cnt - s0, 1);
        send_pkt(8'h08, 8'h02, 8'h02, 322, 238, 0);

        s0 = sync_cnt;
        send_byte(8'h09);
        send_err(1'b1, 8'h05);
        repeat (3) @(negedge clk);
        chk("err_wins_sync_err", sync_cnt - s0, 1);
        send_pkt(8'h09, 8'h03, 8'h03, 325, 235, 1);

        do_reset();
        send_pkt(8'h09, 8'h00, 8'h00, 320, 240, 1);
        s0 = sync_cnt;
        stream_en = 1'b0;
        send_byte(8'hFA);
        send_byte(8'hAA);
        send_byte(8'h00);
        send_err(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        chk("gated_sync_err", sync_cnt - s0, 0);
        chk_outs("gated_hold", 320, 240, 1);

        stream_en = 1'b1;
        send_byte(8'h08);
        send_byte(8'h05);
        @(negedge clk);
        stream_en = 1'b0;
        repeat (2) @(negedge clk);
        stream_en = 1'b1;
        send_pkt(8'h08, 8'h01, 8'h01, 321, 239, 0);

        send_pkt(8'h0A, 8'h05, 8'h03, 326, 236, 2);
        send_byte(8'h08);
        send_byte(8'h05);
        do_reset();
        @(negedge clk);
        chk_outs("mid_pkt_reset", 320, 240, 0);
        send_pkt(8'h08, 8'h01, 8'h01, 321, 239, 0);

        chk("final_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
